// File: rtl/conv_3x3_sched_if.sv
// Handshake and control bundle between the 3x3 conv scheduler, its
// weight/pixel sources and the conv top it feeds.
interface conv_3x3_sched_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CH_IN_W    = 6,
    parameter int CH_OUT_W   = 6
);
    logic                  start;
    logic                  wt_valid;
    logic [DATA_WIDTH-1:0] wt_data;
    logic                  wt_ready;
    logic                  px_valid;
    logic [DATA_WIDTH-1:0] px_data;
    logic                  px_ready;
    logic                  valid_weight_in;
    logic [DATA_WIDTH-1:0] weight_in;
    logic                  valid_in;
    logic [DATA_WIDTH-1:0] pxl_in;
    logic                  conv_valid;
    logic [CH_IN_W-1:0]    ch_in_idx;
    logic [CH_OUT_W-1:0]   ch_out_idx;
    logic                  acc_first;
    logic                  acc_last;
    logic                  busy;
    logic                  done;

    // Sources, conv top and controller side.
    modport master (
        output start, wt_valid, wt_data, px_valid, px_data, conv_valid,
        input  wt_ready, px_ready, valid_weight_in, weight_in, valid_in, pxl_in,
        input  ch_in_idx, ch_out_idx, acc_first, acc_last, busy, done
    );

    // Scheduler side.
    modport slave (
        input  start, wt_valid, wt_data, px_valid, px_data, conv_valid,
        output wt_ready, px_ready, valid_weight_in, weight_in, valid_in, pxl_in,
        output ch_in_idx, ch_out_idx, acc_first, acc_last, busy, done
    );
endinterface

// File: rtl/conv_3x3_sched.sv
// Layer scheduler for a 3x3 convolution engine: for every (output, input)
// channel pair it loads one kernel of weights, streams one feature map of
// pixels, then waits until the conv top has produced every output pixel.
module conv_3x3_sched #(
    parameter int DATA_WIDTH      = 32,
    parameter int IMAGE_WIDTH     = 64,
    parameter int IMAGE_HEIGHT    = 64,
    parameter int CHANNEL_NUM_IN  = 64,
    parameter int CHANNEL_NUM_OUT = 64,
    parameter int KERNEL_SIZE     = 9
) (
    input logic            clk,
    input logic            reset,
    conv_3x3_sched_if.slave bus
);
    localparam int NPIX = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int CI_W = (CHANNEL_NUM_IN  > 1) ? $clog2(CHANNEL_NUM_IN)  : 1;
    localparam int CO_W = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;
    localparam int WC_W = $clog2(KERNEL_SIZE + 1);
    localparam int PC_W = $clog2(NPIX + 1);

    localparam logic [CI_W-1:0] CI_LAST = CI_W'(CHANNEL_NUM_IN - 1);
    localparam logic [CO_W-1:0] CO_LAST = CO_W'(CHANNEL_NUM_OUT - 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(KERNEL_SIZE - 1);
    localparam logic [WC_W-1:0] WC_FULL = WC_W'(KERNEL_SIZE);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(NPIX - 1);
    localparam logic [PC_W-1:0] PC_FULL = PC_W'(NPIX);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN,
        NEXT
    } state_t;

    state_t                state, state_nx;
    logic [WC_W-1:0]       wcnt;
    logic [PC_W-1:0]       pcnt;
    logic [PC_W-1:0]       ocnt;
    logic [CI_W-1:0]       ci_idx;
    logic [CO_W-1:0]       co_idx;
    logic                  wt_ready_c;
    logic                  px_ready_c;
    logic                  busy_c;
    logic                  wt_acc;
    logic                  px_acc;
    logic                  out_cnt_en;
    logic                  last_ci;
    logic                  last_co;
    logic                  done_r;
    logic                  wvalid_r;
    logic                  pvalid_r;
    logic [DATA_WIDTH-1:0] weight_r;
    logic [DATA_WIDTH-1:0] pixel_r;

    assign wt_acc     = wt_ready_c & bus.wt_valid;
    assign px_acc     = px_ready_c & bus.px_valid;
    assign out_cnt_en = bus.conv_valid & (state inside {LOAD_W, STREAM, DRAIN});
    assign last_ci    = (ci_idx == CI_LAST);
    assign last_co    = (co_idx == CO_LAST);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state and handshake/busy decode.
    always_comb begin
        state_nx   = state;
        wt_ready_c = 1'b0;
        px_ready_c = 1'b0;
        busy_c     = 1'b1;
        case (state)
            IDLE: begin
                busy_c = 1'b0;
                if (bus.start) state_nx = LOAD_W;
            end
            LOAD_W: begin
                wt_ready_c = 1'b1;
                if (bus.wt_valid && wcnt == WC_LAST) state_nx = STREAM;
            end
            STREAM: begin
                px_ready_c = 1'b1;
                if (bus.px_valid && pcnt == PC_LAST) state_nx = DRAIN;
            end
            DRAIN: begin
                if (ocnt == PC_FULL) state_nx = NEXT;
            end
            NEXT: begin
                state_nx = (last_ci && last_co) ? IDLE : LOAD_W;
            end
            default: begin
                busy_c   = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    // Weight, pixel and output counters; none may run past its pass limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt <= '0;
            pcnt <= '0;
            ocnt <= '0;
        end else if (state == NEXT) begin
            pcnt <= '0;
            ocnt <= '0;
        end else begin
            if (wt_acc) begin
                if (wcnt == WC_LAST)     wcnt <= '0;
                else if (wcnt < WC_FULL) wcnt <= wcnt + WC_W'(1);
            end
            if (px_acc && pcnt < PC_FULL)     pcnt <= pcnt + PC_W'(1);
            if (out_cnt_en && ocnt < PC_FULL) ocnt <= ocnt + PC_W'(1);
        end
    end

    // Channel indices: cleared on layer start, advanced input-major in NEXT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ci_idx <= '0;
            co_idx <= '0;
        end else if (state == IDLE && bus.start) begin
            ci_idx <= '0;
            co_idx <= '0;
        end else if (state == NEXT) begin
            if (!last_ci) begin
                ci_idx <= ci_idx + CI_W'(1);
            end else begin
                ci_idx <= '0;
                if (!last_co) co_idx <= co_idx + CO_W'(1);
            end
        end
    end

    // Layer-complete pulse lands in the first IDLE cycle after the final NEXT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) done_r <= 1'b0;
        else       done_r <= (state == NEXT) && last_ci && last_co;
    end

    // One-cycle-latency weight/pixel registers toward the conv top; data holds
    // its last accepted word while the strobe is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wvalid_r <= 1'b0;
            pvalid_r <= 1'b0;
            weight_r <= '0;
            pixel_r  <= '0;
        end else begin
            wvalid_r <= wt_acc;
            pvalid_r <= px_acc;
            if (wt_acc) weight_r <= bus.wt_data;
            if (px_acc) pixel_r  <= bus.px_data;
        end
    end

    assign bus.wt_ready        = wt_ready_c;
    assign bus.px_ready        = px_ready_c;
    assign bus.busy            = busy_c;
    assign bus.done            = done_r;
    assign bus.valid_weight_in = wvalid_r;
    assign bus.weight_in       = weight_r;
    assign bus.valid_in        = pvalid_r;
    assign bus.pxl_in          = pixel_r;
    assign bus.ch_in_idx       = ci_idx;
    assign bus.ch_out_idx      = co_idx;
    assign bus.acc_first       = (ci_idx == '0);
    assign bus.acc_last        = last_ci;
endmodule

// File: tb/tb_conv_3x3_sched.sv
// Self-checking bench for conv_3x3_sched on a 4x4 map, 2 in / 2 out channels.
module tb_conv_3x3_sched;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int IH = 4;
    localparam int CI = 2;
    localparam int CO = 2;
    localparam int KS = 9;
    localparam int NPIX = IW * IH;
    localparam int NPASS = CI * CO;

    logic clk = 1'b0;
    logic reset;

    conv_3x3_sched_if #(.DATA_WIDTH(DW), .CH_IN_W(1), .CH_OUT_W(1)) bus ();

    conv_3x3_sched #(
        .DATA_WIDTH(DW), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH),
        .CHANNEL_NUM_IN(CI), .CHANNEL_NUM_OUT(CO), .KERNEL_SIZE(KS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // source / sink controls
    bit wt_en, px_en, px_toggle, echo_en, px_phase;
    logic [4:0] echo_sr;

    // scoreboard
    logic [DW-1:0] px_q[$];
    logic [DW-1:0] wt_q[$];
    bit px_pend, wt_pend, in_weights;
    logic [DW-1:0] last_px, last_wt;

    // per-pass log
    int p_n, done_cnt;
    int p_co[16], p_ci[16], p_af[16], p_al[16], p_wt[16], p_px[16];

    // Source and conv_valid echo drivers, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            echo_sr = {echo_sr[3:0], bus.valid_in === 1'b1};
            if (echo_en) bus.conv_valid = echo_sr[4];
            px_phase = ~px_phase;
            bus.px_valid = px_en && (!px_toggle || px_phase);
            bus.px_data = $urandom;
            bus.wt_valid = wt_en;
            bus.wt_data = $urandom;
        end
    end

    // Acceptance capture: expected data queued, pass records opened.
    always @(negedge clk) begin
        if (reset !== 1'b0) begin
            px_q.delete();
            wt_q.delete();
            px_pend = 1'b0;
            wt_pend = 1'b0;
            in_weights = 1'b0;
            last_px = '0;
            last_wt = '0;
        end else begin
            px_pend = (bus.px_valid === 1'b1) && (bus.px_ready === 1'b1);
            wt_pend = (bus.wt_valid === 1'b1) && (bus.wt_ready === 1'b1);
            if (wt_pend) begin
                wt_q.push_back(bus.wt_data);
                if (!in_weights && p_n < 16) begin
                    p_co[p_n] = int'(bus.ch_out_idx);
                    p_ci[p_n] = int'(bus.ch_in_idx);
                    p_af[p_n] = int'(bus.acc_first);
                    p_al[p_n] = int'(bus.acc_last);
                    p_wt[p_n] = 0;
                    p_px[p_n] = 0;
                    p_n++;
                end
                in_weights = 1'b1;
            end
            if (px_pend) begin
                px_q.push_back(bus.px_data);
                in_weights = 1'b0;
                total++;
                if (p_n == 0 || int'(bus.ch_in_idx) != p_ci[p_n-1] || int'(bus.ch_out_idx) != p_co[p_n-1]
                    || int'(bus.acc_first) != p_af[p_n-1] || int'(bus.acc_last) != p_al[p_n-1]) begin
                    bad++;
                    $display("FAIL pass_hold got=(%0d,%0d,%0b,%0b) exp=held from pass start",
                             bus.ch_out_idx, bus.ch_in_idx, bus.acc_first, bus.acc_last);
                end
            end
        end
    end

    // Output monitor: strobe latency, data, hold, done pulse.
    initial begin
        logic [DW-1:0] exp;
        forever begin
            @(posedge clk);
            #1;
            if (reset === 1'b0) begin
                total++;
                if (bus.valid_in !== px_pend) begin
                    bad++;
                    $display("FAIL valid_in got=%b exp=%b", bus.valid_in, px_pend);
                end
                exp = last_px;
                if (px_pend) exp = (px_q.size() > 0) ? px_q.pop_front() : 'x;
                total++;
                if (bus.pxl_in !== exp) begin
                    bad++;
                    $display("FAIL pxl_in got=%h exp=%h", bus.pxl_in, exp);
                end
                last_px = exp;
                total++;
                if (bus.valid_weight_in !== wt_pend) begin
                    bad++;
                    $display("FAIL valid_weight_in got=%b exp=%b", bus.valid_weight_in, wt_pend);
                end
                exp = last_wt;
                if (wt_pend) exp = (wt_q.size() > 0) ? wt_q.pop_front() : 'x;
                total++;
                if (bus.weight_in !== exp) begin
                    bad++;
                    $display("FAIL weight_in got=%h exp=%h", bus.weight_in, exp);
                end
                last_wt = exp;
                if (bus.valid_in === 1'b1 && p_n > 0) p_px[p_n-1]++;
                if (bus.valid_weight_in === 1'b1 && p_n > 0) p_wt[p_n-1]++;
                if (bus.done === 1'b1) begin
                    done_cnt++;
                    total++;
                    if (bus.busy !== 1'b0) begin
                        bad++;
                        $display("FAIL done_busy got=%b exp=0", bus.busy);
                    end
                end
            end
        end
    end

    task automatic clear_log();
        p_n = 0;
        done_cnt = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            #2;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s_timeout got=no done exp=done within %0d cycles", name, limit);
        end
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        total++;
        if ({bus.wt_ready, bus.px_ready, bus.valid_in, bus.valid_weight_in, bus.busy, bus.done,
             bus.ch_in_idx, bus.ch_out_idx, bus.acc_first, bus.acc_last} !== 10'b0000_0000_10) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=0000000010",
                     {bus.wt_ready, bus.px_ready, bus.valid_in, bus.valid_weight_in, bus.busy, bus.done,
                      bus.ch_in_idx, bus.ch_out_idx, bus.acc_first, bus.acc_last});
        end
        total++;
        if (bus.pxl_in !== '0 || bus.weight_in !== '0) begin
            bad++;
            $display("FAIL reset_data got=%h/%h exp=0/0", bus.pxl_in, bus.weight_in);
        end
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_nominal();
        clear_log();
        px_toggle = 1'b0;
        echo_en = 1'b1;
        pulse_start();
        wait_done("nominal", 1000);
        total++;
        if (done_cnt != 1 || p_n != NPASS) begin
            bad++;
            $display("FAIL nominal_count got=done %0d passes %0d exp=done 1 passes %0d", done_cnt, p_n, NPASS);
        end
        for (int k = 0; k < NPASS; k++) begin
            total++;
            if (p_co[k] != k / CI || p_ci[k] != k % CI || p_wt[k] != KS || p_px[k] != NPIX) begin
                bad++;
                $display("FAIL nominal_pass%0d got=(%0d,%0d) w=%0d p=%0d exp=(%0d,%0d) w=%0d p=%0d",
                         k, p_co[k], p_ci[k], p_wt[k], p_px[k], k / CI, k % CI, KS, NPIX);
            end
            total++;
            if (p_af[k] != ((k % CI) == 0 ? 1 : 0) || p_al[k] != ((k % CI) == CI - 1 ? 1 : 0)) begin
                bad++;
                $display("FAIL flags_pass%0d got=first %0d last %0d exp=first %0d last %0d",
                         k, p_af[k], p_al[k], (k % CI) == 0, (k % CI) == CI - 1);
            end
        end
        total++;
        if (px_q.size() != 0 || wt_q.size() != 0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL nominal_end got=pxq %0d wtq %0d busy %b exp=0 0 0", px_q.size(), wt_q.size(), bus.busy);
        end
    endtask

    task automatic test_backpressure();
        clear_log();
        px_toggle = 1'b1;
        echo_en = 1'b1;
        pulse_start();
        wait_done("backpressure", 1500);
        px_toggle = 1'b0;
        total++;
        if (done_cnt != 1 || p_n != NPASS) begin
            bad++;
            $display("FAIL bp_count got=done %0d passes %0d exp=done 1 passes %0d", done_cnt, p_n, NPASS);
        end
        for (int k = 0; k < NPASS; k++) begin
            total++;
            if (p_px[k] != NPIX) begin
                bad++;
                $display("FAIL bp_pixels%0d got=%0d exp=%0d", k, p_px[k], NPIX);
            end
        end
    endtask

    task automatic test_drain_hold();
        bit ok = 1'b0;
        clear_log();
        echo_en = 1'b0;
        bus.conv_valid = 1'b0;
        pulse_start();
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #2;
            if (p_n >= 1 && p_px[0] == NPIX) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL drain_reach got=no 16th pixel exp=16 pixels in pass 0");
        end
        repeat (20) @(posedge clk);
        #2;
        total++;
        if ({bus.busy, bus.wt_ready, bus.px_ready, bus.ch_out_idx, bus.ch_in_idx} !== 5'b10000) begin
            bad++;
            $display("FAIL drain_hold got=%b exp=10000",
                     {bus.busy, bus.wt_ready, bus.px_ready, bus.ch_out_idx, bus.ch_in_idx});
        end
        repeat (15) @(negedge clk) bus.conv_valid = 1'b1;
        @(negedge clk) bus.conv_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        total++;
        if ({bus.busy, bus.wt_ready, bus.px_ready} !== 3'b100) begin
            bad++;
            $display("FAIL drain_15 got=%b exp=100", {bus.busy, bus.wt_ready, bus.px_ready});
        end
        @(negedge clk) bus.conv_valid = 1'b1;
        @(negedge clk) bus.conv_valid = 1'b0;
        @(posedge clk);
        #2;
        total++;
        if ({bus.busy, bus.wt_ready} !== 2'b10) begin
            bad++;
            $display("FAIL drain_next got=%b exp=10", {bus.busy, bus.wt_ready});
        end
        @(posedge clk);
        #2;
        total++;
        if ({bus.wt_ready, bus.ch_out_idx, bus.ch_in_idx} !== 3'b101) begin
            bad++;
            $display("FAIL drain_loadw got=%b exp=101", {bus.wt_ready, bus.ch_out_idx, bus.ch_in_idx});
        end
        echo_en = 1'b1;
        wait_done("drain", 1000);
        total++;
        if (done_cnt != 1 || p_n != NPASS) begin
            bad++;
            $display("FAIL drain_layer got=done %0d passes %0d exp=1 %0d", done_cnt, p_n, NPASS);
        end
    endtask

    task automatic test_reset_mid();
        bit ok = 1'b0;
        clear_log();
        echo_en = 1'b1;
        pulse_start();
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #2;
            if (p_n >= 3 && p_px[2] >= 5) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok || p_co[2] != 1 || p_ci[2] != 0) begin
            bad++;
            $display("FAIL midrst_reach got=ok %0b pass2 (%0d,%0d) exp=ok 1 (1,0)", ok, p_co[2], p_ci[2]);
        end
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        total++;
        if ({bus.wt_ready, bus.px_ready, bus.valid_in, bus.valid_weight_in, bus.busy, bus.done,
             bus.ch_in_idx, bus.ch_out_idx, bus.acc_first, bus.acc_last} !== 10'b0000_0000_10) begin
            bad++;
            $display("FAIL midrst_ctrl got=%b exp=0000000010",
                     {bus.wt_ready, bus.px_ready, bus.valid_in, bus.valid_weight_in, bus.busy, bus.done,
                      bus.ch_in_idx, bus.ch_out_idx, bus.acc_first, bus.acc_last});
        end
        total++;
        if (bus.pxl_in !== '0 || bus.weight_in !== '0) begin
            bad++;
            $display("FAIL midrst_data got=%h/%h exp=0/0", bus.pxl_in, bus.weight_in);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        total++;
        if (done_cnt != 0) begin
            bad++;
            $display("FAIL midrst_done got=%0d exp=0", done_cnt);
        end
        clear_log();
        pulse_start();
        wait_done("midrst", 1000);
        total++;
        if (p_n != NPASS || p_co[0] != 0 || p_ci[0] != 0 || done_cnt != 1) begin
            bad++;
            $display("FAIL midrst_restart got=passes %0d first (%0d,%0d) done %0d exp=%0d (0,0) 1",
                     p_n, p_co[0], p_ci[0], done_cnt, NPASS);
        end
    endtask

    task automatic test_start_busy();
        bit ok = 1'b0;
        clear_log();
        echo_en = 1'b1;
        pulse_start();
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #2;
            if (p_n >= 1 && p_px[0] >= 3) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL busy_reach got=no stream exp=pass 0 streaming");
        end
        pulse_start();
        repeat (40) @(posedge clk);
        pulse_start();
        wait_done("start_busy", 1000);
        repeat (30) @(posedge clk);
        #2;
        total++;
        if (done_cnt != 1 || p_n != NPASS || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL start_busy got=done %0d passes %0d busy %b exp=1 %0d 0", done_cnt, p_n, bus.busy, NPASS);
        end
        for (int k = 0; k < NPASS; k++) begin
            total++;
            if (p_co[k] != k / CI || p_ci[k] != k % CI) begin
                bad++;
                $display("FAIL start_busy_pass%0d got=(%0d,%0d) exp=(%0d,%0d)", k, p_co[k], p_ci[k], k / CI, k % CI);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.wt_valid = 1'b0;
        bus.wt_data = '0;
        bus.px_valid = 1'b0;
        bus.px_data = '0;
        bus.conv_valid = 1'b0;
        wt_en = 1'b1;
        px_en = 1'b1;
        px_toggle = 1'b0;
        echo_en = 1'b1;
        px_phase = 1'b0;
        echo_sr = '0;
        p_n = 0;
        done_cnt = 0;
        test_reset();
        test_nominal();
        test_backpressure();
        test_drain_hold();
        test_reset_mid();
        test_start_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
